adc_seq_ctrl: RTL and testbench

//  Multi-precision add/subtract sequencer around the ADC32 32-bit adder (A+B+C0 -> 33-bit S).

---
 rtl/adc_seq_ctrl_pkg.sv | 19 +
 rtl/adc_seq_ctrl_adc32.sv | 13 +
 rtl/adc_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_adc_seq_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_ctrl_pkg.sv
// Shared types and helpers for the adc_seq_ctrl multi-word add/subtract sequencer.
package adc_seq_ctrl_pkg;

   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

   // Subtraction is A + ~B + 1, with the +1 supplied as the initial carry.
   function automatic logic [WORD_W-1:0] operand_b(input logic [WORD_W-1:0] b,
                                                    input logic              sub);
      return sub ? ~b : b;
   endfunction

endpackage

// File: rtl/adc_seq_ctrl_adc32.sv
// ADC32: 32-bit adder with carry in, producing a 33-bit result (carry in the top bit).
module adc_seq_ctrl_adc32
   import adc_seq_ctrl_pkg::*;
(
   input  logic [WORD_W-1:0] a_i,
   input  logic [WORD_W-1:0] b_i,
   input  logic              c0_i,
   output logic [WORD_W:0]   s_o
);

   assign s_o = {1'b0, a_i} + {1'b0, b_i} + {{WORD_W{1'b0}}, c0_i};

endmodule

// File: rtl/adc_seq_ctrl.sv
// Multi-word add/subtract sequencer: streams word pairs LS-first through ADC32, chaining carry.
// Optional signed-overflow flag on the final word is enabled with `define OVF_DETECT_EN.
module adc_seq_ctrl
   import adc_seq_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              sub,
   input  logic [CNT_W-1:0]  n_words,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] a_in,
   input  logic [WORD_W-1:0] b_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] s_out,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              carry_out,
   output logic              ovf
);

   state_e            state_q, state_d;
   logic              sub_q, sub_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              carry_q, carry_d;
   logic [WORD_W-1:0] s_q, s_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              carry_out_q, carry_out_d;

   logic [WORD_W-1:0] b_eff;
   logic [WORD_W:0]   sum;
   logic              in_fire, out_fire, last_word;

   assign b_eff = operand_b(b_in, sub_q);

   adc_seq_ctrl_adc32 u_adc32 (
      .a_i  (a_in),
      .b_i  (b_eff),
      .c0_i (carry_q),
      .s_o  (sum)
   );

   // Single output register: a new word may enter only if the current one leaves this cycle.
   assign in_ready  = (state_q == StRun) && (!out_valid_q || out_ready);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid_q && out_ready;
   assign last_word = (cnt_q == n_q - CNT_W'(1));

   always_comb begin
      state_d     = state_q;
      sub_d       = sub_q;
      n_d         = n_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      s_d         = s_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      carry_out_d = carry_out_q;
      unique case (state_q)
         StIdle: begin
            if (start && (n_words != '0)) begin
               sub_d   = sub;
               n_d     = n_words;
               cnt_d   = '0;
               carry_d = sub;
               state_d = StRun;
            end
         end
         StRun: begin
            if (in_fire) begin
               s_d         = sum[WORD_W-1:0];
               carry_d     = sum[WORD_W];
               out_valid_d = 1'b1;
               out_last_d  = last_word;
               if (last_word) begin
                  state_d = StDrain;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (out_fire) begin
               out_valid_d = 1'b0;
            end
         end
         StDrain: begin
            if (out_fire) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               carry_out_d = carry_q;
               state_d     = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         sub_q       <= 1'b0;
         n_q         <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         s_q         <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         carry_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sub_q       <= sub_d;
         n_q         <= n_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         s_q         <= s_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         carry_out_q <= carry_out_d;
      end
   end

`ifdef OVF_DETECT_EN
   logic ovf_pend_q, ovf_pend_d;
   logic ovf_q, ovf_d;

   // Captured at the last-word fire, published together with carry_out.
   always_comb begin
      ovf_pend_d = ovf_pend_q;
      ovf_d      = ovf_q;
      if (in_fire && last_word) begin
         ovf_pend_d = (a_in[WORD_W-1] == b_eff[WORD_W-1]) &&
                      (sum[WORD_W-1] != a_in[WORD_W-1]);
      end
      if ((state_q == StDrain) && out_fire) begin
         ovf_d = ovf_pend_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_pend_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         ovf_pend_q <= ovf_pend_d;
         ovf_q      <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign out_valid = out_valid_q;
   assign s_out     = s_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);
   assign carry_out = carry_out_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Directed self-checking bench for adc_seq_ctrl: one task per scenario, hand-computed results.
module tb_adc_seq_ctrl;

`ifdef OVF_DETECT_EN
   localparam bit ExpOvf = 1'b1;
`else
   localparam bit ExpOvf = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sub;
   logic [3:0]  n_words;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] s_out;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        carry_out;
   logic        ovf;

   int errors = 0;
   int checks = 0;

   logic [31:0] got_s[$];
   logic        got_last[$];
   int          done_cnt;
   logic        got_cout;
   logic        got_ovf;

   adc_seq_ctrl #(
      .CNT_W (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sub       (sub),
      .n_words   (n_words),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s_out     (s_out),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .carry_out (carry_out),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Output-side monitor; sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         got_s.push_back(s_out);
         got_last.push_back(out_last);
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         got_cout = carry_out;
         got_ovf  = ovf;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got_s.delete();
      got_last.delete();
      done_cnt = 0;
      got_cout = 1'bx;
      got_ovf  = 1'bx;
   endtask

   task automatic feed(input logic [31:0] a, input logic [31:0] b);
      bit fired = 1'b0;
      int k = 0;
      in_valid = 1'b1;
      a_in     = a;
      b_in     = b;
      while (!fired && k < 20) begin
         @(negedge clk);
         fired = in_ready;
         tick();
         k++;
      end
      in_valid = 1'b0;
      checks++;
      if (!fired) begin
         errors++;
         $display("FAIL feed_timeout: in_ready stayed %b for 20 cycles, required 1", in_ready);
      end
   endtask

   task automatic wait_done();
      int k = 0;
      while (done_cnt == 0 && k < 40) begin
         tick();
         k++;
      end
      checks++;
      if (done_cnt == 0) begin
         errors++;
         $display("FAIL done_timeout: done count %0d after 40 cycles, required 1", done_cnt);
      end
      tick();
      tick();
   endtask

   // noisy: keep start asserted with different sub/n_words while the operation runs.
   task automatic run_op(input logic s, input int n, input logic [31:0] av[4],
                         input logic [31:0] bv[4], input bit noisy);
      clear_mon();
      start   = 1'b1;
      sub     = s;
      n_words = n[3:0];
      tick();
      start = 1'b0;
      if (noisy) begin
         start   = 1'b1;
         sub     = ~s;
         n_words = 4'd1;
      end
      for (int i = 0; i < n; i++) begin
         feed(av[i], bv[i]);
      end
      start = 1'b0;
      sub   = s;
      wait_done();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, in_ready, out_valid, out_last, done, carry_out, ovf} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: busy,in_ready,out_valid,out_last,done,carry_out,ovf=%b want 0000000",
                  {busy, in_ready, out_valid, out_last, done, carry_out, ovf});
      end
      checks++;
      if (s_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_s_out: got %h want 00000000", s_out);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_one_word();
      logic [31:0] av[4] = '{32'd1, 32'd0, 32'd0, 32'd0};
      logic [31:0] bv[4] = '{32'd1, 32'd0, 32'd0, 32'd0};
      run_op(1'b0, 1, av, bv, 1'b0);
      checks++;
      if (got_s.size() != 1) begin
         errors++;
         $display("FAIL one_word_count: got %0d words want 1", got_s.size());
      end else begin
         checks++;
         if (got_s[0] !== 32'h2 || got_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL one_word_sum: got %h last %b want 00000002 last 1",
                     got_s[0], got_last[0]);
         end
      end
      checks++;
      if (done_cnt !== 1 || got_cout !== 1'b0) begin
         errors++;
         $display("FAIL one_word_done: done cycles %0d carry_out %b want 1 cycle carry_out 0",
                  done_cnt, got_cout);
      end
   endtask

   task automatic test_two_words();
      logic [31:0] av[4] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
      logic [31:0] bv[4] = '{32'h0000_0001, 32'h0, 32'h0, 32'h0};
      run_op(1'b0, 2, av, bv, 1'b1);
      checks++;
      if (got_s.size() != 2) begin
         errors++;
         $display("FAIL two_words_count: got %0d words want 2", got_s.size());
      end else begin
         checks++;
         if (got_s[0] !== 32'h0 || got_s[1] !== 32'h1 || got_last[0] !== 1'b0 ||
             got_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL two_words_sum: got %h/%b %h/%b want 00000000/0 00000001/1",
                     got_s[0], got_last[0], got_s[1], got_last[1]);
         end
      end
      checks++;
      if (done_cnt !== 1 || got_cout !== 1'b0) begin
         errors++;
         $display("FAIL two_words_done: done cycles %0d carry_out %b want 1 and 0",
                  done_cnt, got_cout);
      end
   endtask

   task automatic test_sub();
      logic [31:0] av[4] = '{32'd1, 32'd0, 32'd0, 32'd0};
      logic [31:0] bv[4] = '{32'd7, 32'd0, 32'd0, 32'd0};
      run_op(1'b1, 1, av, bv, 1'b0);
      checks++;
      if (got_s.size() != 1 || got_s[0] !== 32'hFFFF_FFFA || got_cout !== 1'b0) begin
         errors++;
         $display("FAIL sub_borrow: words %0d s %h carry_out %b want 1 FFFFFFFA 0",
                  got_s.size(), got_s.size() ? got_s[0] : 32'hx, got_cout);
      end
      av[0] = 32'd7;
      bv[0] = 32'd1;
      run_op(1'b1, 1, av, bv, 1'b0);
      checks++;
      if (got_s.size() != 1 || got_s[0] !== 32'h6 || got_cout !== 1'b1) begin
         errors++;
         $display("FAIL sub_no_borrow: words %0d s %h carry_out %b want 1 00000006 1",
                  got_s.size(), got_s.size() ? got_s[0] : 32'hx, got_cout);
      end
      checks++;
      if (carry_out !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL sub_hold: carry_out %b busy %b want 1 0", carry_out, busy);
      end
   endtask

   task automatic test_zero_start();
      start   = 1'b1;
      n_words = 4'd0;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL zero_start: busy %b in_ready %b want 0 0", busy, in_ready);
      end
   endtask

   task automatic test_rst_mid();
      logic [31:0] av[4] = '{32'd1, 32'd0, 32'd0, 32'd0};
      logic [31:0] bv[4] = '{32'd1, 32'd0, 32'd0, 32'd0};
      clear_mon();
      start   = 1'b1;
      sub     = 1'b0;
      n_words = 4'd3;
      tick();
      start = 1'b0;
      feed(32'h1234_5678, 32'h1111_1111);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || carry_out !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: busy %b out_valid %b carry_out %b want 0 0 0",
                  busy, out_valid, carry_out);
      end
      run_op(1'b0, 1, av, bv, 1'b0);
      checks++;
      if (got_s.size() != 1 || got_s[0] !== 32'h2 || done_cnt !== 1) begin
         errors++;
         $display("FAIL rst_mid_rerun: words %0d s %h done %0d want 1 00000002 1",
                  got_s.size(), got_s.size() ? got_s[0] : 32'hx, done_cnt);
      end
   endtask

   task automatic test_backpressure();
      bit ok = 1'b1;
      clear_mon();
      start   = 1'b1;
      sub     = 1'b0;
      n_words = 4'd3;
      tick();
      start = 1'b0;
      feed(32'hFFFF_FFFF, 32'h0000_0001);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a_in      = 32'h8000_0000;
      b_in      = 32'h8000_0000;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || s_out !== 32'h0 || out_last !== 1'b0) begin
            errors++;
            ok = 1'b0;
            $display("FAIL bp_stall%0d: in_ready %b out_valid %b s_out %h last %b want 0 1 00000000 0",
                     j, in_ready, out_valid, s_out, out_last);
         end
         tick();
      end
      out_ready = 1'b1;
      feed(32'h8000_0000, 32'h8000_0000);
      feed(32'h0000_0005, 32'h0000_0002);
      wait_done();
      checks++;
      if (got_s.size() != 3) begin
         errors++;
         $display("FAIL bp_count: got %0d words want 3 (stall ok=%b)", got_s.size(), ok);
      end else begin
         checks++;
         if (got_s[0] !== 32'h0 || got_s[1] !== 32'h1 || got_s[2] !== 32'h8 ||
             {got_last[0], got_last[1], got_last[2]} !== 3'b001) begin
            errors++;
            $display("FAIL bp_sum: got %h %h %h last %b%b%b want 00000000 00000001 00000008 001",
                     got_s[0], got_s[1], got_s[2], got_last[0], got_last[1], got_last[2]);
         end
      end
      checks++;
      if (got_cout !== 1'b0 || done_cnt !== 1) begin
         errors++;
         $display("FAIL bp_done: carry_out %b done %0d want 0 1", got_cout, done_cnt);
      end
   endtask

   task automatic test_ovf();
      logic [31:0] av[4] = '{32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0};
      logic [31:0] bv[4] = '{32'h0000_0001, 32'h0, 32'h0, 32'h0};
      run_op(1'b0, 1, av, bv, 1'b0);
      checks++;
      if (got_s.size() != 1 || got_s[0] !== 32'h8000_0000 || got_cout !== 1'b0) begin
         errors++;
         $display("FAIL ovf_sum: words %0d s %h carry_out %b want 1 80000000 0",
                  got_s.size(), got_s.size() ? got_s[0] : 32'hx, got_cout);
      end
      checks++;
      if (got_ovf !== ExpOvf || ovf !== ExpOvf) begin
         errors++;
         $display("FAIL ovf_flag: at done %b held %b want %b", got_ovf, ovf, ExpOvf);
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      sub       = 1'b0;
      n_words   = 4'd0;
      in_valid  = 1'b0;
      a_in      = 32'h0;
      b_in      = 32'h0;
      out_ready = 1'b1;
      clear_mon();
      test_reset();
      test_one_word();
      test_two_words();
      test_sub();
      test_zero_start();
      test_rst_mid();
      test_backpressure();
      test_ovf();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, required finish");
      $fatal(1);
   end

endmodule
